// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry and the hard-wired zero register.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned ZERO_REG  = 0;

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: a WIDTH-bit register with load enable
// and asynchronous active-low clear.
module reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file with one write port and two combinational read ports; register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs [DEPTH];

    // Register 0 is a constant, so writes to it simply have nowhere to land.
    assign regs[ZERO_REG] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_word
        logic en;
        assign en = we && (waddr == AW'(i));

        reg_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .d       (wdata),
            .q       (regs[i])
        );
    end

    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by reset so a held-in-reset file still reads as zero.
        if (reset_n && we && (waddr != '0)) begin
            if (raddr_a == waddr) begin
                rdata_a = wdata;
            end
            if (raddr_b == waddr) begin
                rdata_b = wdata;
            end
        end
`endif
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width of each register in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers (power of two, >= 2).
REQ-003 The block SHALL have derived parameter AW, default clog2(DEPTH), meaning address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port we, input, 1 bit: write enable.
REQ-007 The block SHALL have port waddr, input, AW bits: write address.
REQ-008 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-009 The block SHALL have port raddr_a, input, AW bits: read port A address.
REQ-010 The block SHALL have port rdata_a, output, WIDTH bits: read port A data.
REQ-011 The block SHALL have port raddr_b, input, AW bits: read port B address.
REQ-012 The block SHALL have port rdata_b, output, WIDTH bits: read port B data.

Function
REQ-013 On a rising clk edge with we=1, reset_n=1 and waddr!=0, register[waddr] SHALL take wdata; all other registers SHALL hold.
REQ-014 A write with waddr=0 SHALL be discarded; register 0 SHALL always read as all-zeros.
REQ-015 A write with we=0 SHALL leave every register unchanged regardless of waddr and wdata.
REQ-016 Reads SHALL be combinational: rdata_a = register[raddr_a] and rdata_b = register[raddr_b], both with zero-cycle latency.
REQ-017 Both read ports SHALL be independent; raddr_a==raddr_b SHALL return identical data on both ports.
REQ-018 A register written at edge N SHALL be visible on the read ports immediately after edge N.
REQ-019 Registers SHALL retain their value indefinitely while we=0 and reset_n=1.

Reset
REQ-020 reset_n=0 SHALL immediately clear every register to 0, independent of clk, so that rdata_a=rdata_b=0.
REQ-021 A write on the same edge on which reset_n is low SHALL be ignored.
REQ-022 Reset deassertion SHALL take effect from the first rising clk edge after reset_n goes high.

Configuration
REQ-023 When macro REGFILE_BYPASS_EN is defined, a read port whose address equals waddr while we=1 and waddr!=0 SHALL output wdata in the same cycle (write-through forwarding).
REQ-024 When REGFILE_BYPASS_EN is undefined, such a read SHALL return the old register contents until the edge completes.
REQ-025 With or without the macro, reads of address 0 SHALL return 0, and bypass SHALL be suppressed while reset_n=0.

Structure
REQ-026 Package regfile_pkg SHALL hold the default WIDTH and DEPTH constants and the zero-register index constant.
REQ-027 Each storage word SHALL be an instance of sub-module reg_word: a WIDTH-bit register with enable and asynchronous active-low clear, generated DEPTH-1 times.
REQ-028 Register 0 SHALL be a constant; no reg_word instance SHALL be created for it.
REQ-029 Write-enable decode and read multiplexers SHALL reside in register_file.

Verification
REQ-030 Reset check: after reset_n=0 mid-run, reads of every address SHALL return 0 with no clk edge required.
REQ-031 Write/read check: write 0xDEADBEEF to address 5, then set raddr_a=5 and raddr_b=5; both SHALL read 0xDEADBEEF.
REQ-032 Zero-register check: write 0xFFFFFFFF to address 0, then read address 0; the result SHALL be 0.
REQ-033 Enable check: with we=0, drive waddr=7 and wdata=0x1234 for 3 edges; address 7 SHALL keep its prior value 0xA5A5A5A5.
REQ-034 Same-cycle check: with we=1, waddr=3, wdata=0x55 and raddr_a=3, where register 3 holds 0x11, rdata_a before the edge SHALL be 0x55 with REGFILE_BYPASS_EN and 0x11 without it.
REQ-035 Parameter sweep: rerun REQ-031 to REQ-033 with WIDTH=8 and DEPTH=4, covering top-address 3 wrap and no aliasing to address 0.
